// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants: next-PC select encodings, reset PC and IF/ID layout.
// Decode and hazard logic import the same encodings so the select field means one thing everywhere.
package if_stage_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } ifid_t;

endpackage

// File: rtl/if_stage_npc.sv
// Combinational next-PC selection.
// Branch and jump targets are based on the D-stage PC, because of the delay slot.
module npc
  import if_stage_pkg::*;
(
  input  logic [1:0]  npc_op,
  input  logic        br,
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_fwd,
  output logic [31:0] pc_next
);

  logic [31:0] br_off;

  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    pc_next = pc_f + 32'd4;
    case (npc_op)
      NPC_BR:  if (br) pc_next = pc_d + 32'd4 + br_off;
      NPC_J:   pc_next = {pc_d[31:28], index26, 2'b00};
      NPC_JR:  pc_next = {rs_fwd[31:2], 2'b00};
      default: pc_next = pc_f + 32'd4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch PC register, IF/ID pipeline register and sticky jr-misalignment flag.
// A redirect never flushes IF/ID; the instruction already being fetched is the delay slot.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        br,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_fwd,
  input  logic [31:0] im_instr,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        misalign_err
);

  ifid_t       ifid;
  logic [31:0] pc_next;
  logic        jr_misalign;

  npc u_npc (
    .npc_op  (npc_op),
    .br      (br),
    .pc_f    (pc_f),
    .pc_d    (pc_d),
    .imm16   (imm16),
    .index26 (index26),
    .rs_fwd  (rs_fwd),
    .pc_next (pc_next)
  );

  assign jr_misalign = (npc_op == NPC_JR) && (rs_fwd[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f         <= RESET_PC;
      ifid         <= '{ir: 32'h0, pc: RESET_PC};
      misalign_err <= 1'b0;
    end else if (!stall) begin
      pc_f    <= pc_next;
      ifid.ir <= im_instr;
      ifid.pc <= pc_f;
      if (jr_misalign) misalign_err <= 1'b1;
    end
  end

  assign ir_d  = ifid.ir;
  assign pc_d  = ifid.pc;
  assign pc8_d = ifid.pc + 32'd8;

endmodule
